credit_lookup: RTL and testbench

- Stream-driven table-lookup engine.
- Each 8-bit input token is an address into an internal 256x16 RAM; the 16-bit word read there is emitted on an output stream, in input order.
- Read latency is hidden by an output FIFO guarded by a credit counter: a read is issued only when its result has a guaranteed FIFO slot, so out_tready back-pressure never loses data.
- A separate write port loads the table.

---
 rtl/lookup_ram_256x16.sv | 49 ++++
 rtl/credit_lookup.sv | 92 +++++++++
 tb/tb_credit_lookup.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lookup_ram_256x16.sv
// 256x16 synchronous RAM, one write and one read port, two-stage registered read.
// A read samples the array on its issue edge, so a same-edge write is not observed.
module lookup_ram_256x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_read,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid
);

    logic [15:0] mem [256];
    logic [15:0] stage_q;
    logic        stage_vld_q;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_read) begin
            stage_q <= mem[rd_addr];
        end
        if (stage_vld_q) begin
            rd_data_q <= stage_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            stage_vld_q <= rd_read;
            rd_valid_q  <= stage_vld_q;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/credit_lookup.sv
// Stream lookup engine: input tokens address a 256x16 table, results leave through
// an output FIFO; a credit counter admits a read only when its FIFO slot is reserved.
module credit_lookup #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [15:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    input  logic        wr_valid,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data
);

    localparam int unsigned CREDIT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(FIFO_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);
    localparam logic [PTR_W:0]      PTR_ONE     = (PTR_W + 1)'(1);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [15:0]         fifo_q [FIFO_DEPTH];

    logic        in_hs;
    logic        out_hs;
    logic        fifo_empty;
    logic [15:0] ram_rd_data;
    logic        ram_rd_valid;

    lookup_ram_256x16 u_ram (
        .clk      (aclk),
        .rst      (areset),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_read  (in_hs),
        .rd_addr  (in_tdata),
        .rd_data  (ram_rd_data),
        .rd_valid (ram_rd_valid)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign in_tready  = (credit_q != '0) && !areset;
    assign out_tvalid = !fifo_empty && !areset;
    assign out_tdata  = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign in_hs      = in_tvalid && in_tready;
    assign out_hs     = out_tvalid && out_tready;

    always_comb begin
        credit_d = credit_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({in_hs, out_hs})
            2'b10:   credit_d = credit_q - CREDIT_ONE;
            2'b01:   credit_d = credit_q + CREDIT_ONE;
            default: credit_d = credit_q;
        endcase
        if (ram_rd_valid) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (out_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            credit_q <= CREDIT_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (ram_rd_valid) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_credit_lookup.sv
// Directed and random bench for credit_lookup with a queue scoreboard and a
// monitor that checks ordering, data, stall stability and first-result latency.
module tb_credit_lookup;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic [15:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    typedef struct {
        logic [15:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] tbmem [256];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          check_lat = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    bit          rnd_en;

    credit_lookup #(.FIFO_DEPTH(16)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor: sampled at negedge, pops before pushes, model write last
    // so a lookup issued on the same edge as a write sees the old table word.
    always @(negedge aclk) begin
        exp_t e;
        if (areset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, out_tvalid}, 32'd1);
                chk("hold_data", {16'b0, out_tdata}, {16'b0, prev_data});
            end
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {16'b0, out_tdata}, {16'b0, e.data});
                    if (check_lat) chk("latency", cyc - e.cyc, 32'd3);
                end
            end
            prev_stall = out_tvalid && !out_tready;
            prev_data  = out_tdata;
            if (in_tvalid && in_tready) sb.push_back('{tbmem[in_tdata], cyc});
        end
        if (wr_valid) tbmem[wr_addr] = wr_data;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] a);
        int unsigned t = 0;
        in_tvalid = 1'b1;
        in_tdata  = a;
        do begin
            @(negedge aclk);
            t++;
        end while (!in_tready && t < 200);
        if (!in_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_tready expected handshake for %0h", a);
        end
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        bit done = 1'b0;
        while (!done && t < 600) begin
            @(negedge aclk);
            t++;
            if (sb.size() == 0 && !out_tvalid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        tick();
    endtask

    // Holds in_tvalid for 40 cycles with the output stalled and counts accepts.
    task automatic accept_count(input logic [7:0] base, output int acc);
        bit took;
        acc = 0;
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = base;
        repeat (40) begin
            @(negedge aclk);
            took = in_tready;
            if (took) acc++;
            tick();
            if (took) in_tdata = in_tdata + 8'd1;
        end
    endtask

    initial begin
        int acc;
        areset     = 1'b1;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        repeat (3) tick();
        @(negedge aclk);
        chk("reset_out_tvalid", {31'b0, out_tvalid}, 32'd0);
        chk("reset_in_tready", {31'b0, in_tready}, 32'd0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        chk("ready_after_reset", {31'b0, in_tready}, 32'd1);
        chk("empty_after_reset", {31'b0, out_tvalid}, 32'd0);
        tick();

        for (int a = 0; a < 256; a++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'(a);
            wr_data  = 16'(16'h0A00 + a);
            tick();
        end
        wr_valid = 1'b0;

        out_tready = 1'b1;
        check_lat  = 1'b1;
        send(8'h00);
        send(8'h01);
        send(8'h02);
        wait_drain();
        check_lat = 1'b0;

        fork
            for (int a = 8'h10; a <= 8'h1F; a++) send(8'(a));
            begin
                out_tready = 1'b0;
                repeat (4) tick();
                out_tready = 1'b1;
            end
        join
        wait_drain();

        accept_count(8'h20, acc);
        chk("accepts_when_stalled", acc, 32'd16);
        in_tvalid = 1'b0;
        @(negedge aclk);
        chk("no_credit_tready", {31'b0, in_tready}, 32'd0);
        tick();
        out_tready = 1'b1;
        send(8'h40);
        wait_drain();

        fork
            for (int a = 8'h30; a <= 8'h39; a++) send(8'(a));
            begin
                out_tready = 1'b0;
                repeat (12) tick();
                out_tready = 1'b1;
            end
        join
        wait_drain();
        accept_count(8'h80, acc);
        chk("credit_restored", acc, 32'd16);
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        wait_drain();

        wr_valid = 1'b1;
        wr_addr  = 8'h55;
        wr_data  = 16'h1234;
        tick();
        wr_valid = 1'b0;
        send(8'h55);
        wait_drain();
        wr_valid = 1'b1;
        wr_addr  = 8'h66;
        wr_data  = 16'hBEEF;
        send(8'h66);
        wr_valid = 1'b0;
        send(8'h66);
        wait_drain();

        rnd_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(8'($urandom_range(0, 255)));
                end
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    out_tready = 1'b1;
                    repeat ($urandom_range(0, 24)) tick();
                    out_tready = 1'b0;
                    repeat ($urandom_range(1, 32)) tick();
                end
                out_tready = 1'b1;
            end
        join
        wait_drain();

        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_tdata = 8'(8'h70 + i);
            tick();
        end
        @(negedge aclk);
        chk("valid_before_reset", {31'b0, out_tvalid}, 32'd1);
        tick();
        areset = 1'b1;
        @(negedge aclk);
        chk("reset_mid_tvalid", {31'b0, out_tvalid}, 32'd0);
        chk("reset_mid_tready", {31'b0, in_tready}, 32'd0);
        tick();
        in_tvalid = 1'b0;
        areset    = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            chk("flushed_after_reset", {31'b0, out_tvalid}, 32'd0);
        end
        tick();
        accept_count(8'hA0, acc);
        chk("credit_after_reset", acc, 32'd16);
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        wait_drain();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
